// File: rtl/mem_copy_engine.sv
// mem_copy_engine: bus initiator that copies or fills whole words on the
// data-memory port. It honours the responder's stall handshake and keeps a
// running checksum of all the data it writes.
module mem_copy_engine #(
   parameter int unsigned CNT_W     = 16,
   parameter logic [3:0]  WORD_MASK = 4'b1111
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [CNT_W-1:0] word_count,
   input  logic [31:0]      fill_pattern,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [31:0]      checksum,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             mem_write,
   output logic             mem_read,
   output logic [3:0]       mem_sign_mask,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_stall
);

   localparam int unsigned AW = 32;
   localparam logic [AW-1:0] WORD_ALIGN = 32'hFFFF_FFFC;
   localparam logic [AW-1:0] WORD_BYTES = 32'd4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR_ISSUE = 3'd3,
      WR_WAIT  = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t           state, state_d;
   logic [AW-1:0]    src_q, src_d;
   logic [AW-1:0]    dst_q, dst_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             mode_q, mode_d;
   logic [31:0]      fill_q, fill_d;
   logic             abort_q, abort_d;

   logic             busy_d, done_d, aborted_d;
   logic [31:0]      checksum_d;
   logic [AW-1:0]    addr_d;
   logic [31:0]      wdata_d;
   logic             read_d, write_d;
   logic [3:0]       mask_d;

   logic             abort_hit;
   logic [CNT_W-1:0] rem_dec;
   logic [AW-1:0]    src_inc, dst_inc;
   logic [AW-1:0]    src_start, dst_start;

   // State, command context and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         src_q         <= '0;
         dst_q         <= '0;
         rem_q         <= '0;
         mode_q        <= 1'b0;
         fill_q        <= '0;
         abort_q       <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         aborted       <= 1'b0;
         checksum      <= '0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_sign_mask <= '0;
      end else begin
         state         <= state_d;
         src_q         <= src_d;
         dst_q         <= dst_d;
         rem_q         <= rem_d;
         mode_q        <= mode_d;
         fill_q        <= fill_d;
         abort_q       <= abort_d;
         busy          <= busy_d;
         done          <= done_d;
         aborted       <= aborted_d;
         checksum      <= checksum_d;
         mem_addr      <= addr_d;
         mem_wdata     <= wdata_d;
         mem_read      <= read_d;
         mem_write     <= write_d;
         mem_sign_mask <= mask_d;
      end
   end

   // Next state, datapath updates and next values of the registered outputs.
   always_comb begin
      state_d    = state;
      src_d      = src_q;
      dst_d      = dst_q;
      rem_d      = rem_q;
      mode_d     = mode_q;
      fill_d     = fill_q;
      abort_d    = abort_q;
      aborted_d  = aborted;
      checksum_d = checksum;
      addr_d     = mem_addr;
      wdata_d    = mem_wdata;

      // The live abort is included so that a request arriving in the
      // completing cycle itself is not lost.
      abort_hit = abort_q | abort;
      rem_dec   = (rem_q != '0) ? rem_q - CNT_W'(1) : rem_q;
      src_inc   = src_q + WORD_BYTES;
      dst_inc   = dst_q + WORD_BYTES;
      src_start = src_addr & WORD_ALIGN;
      dst_start = dst_addr & WORD_ALIGN;

      // The sticky abort flag only listens while a command is running.
      if (state != IDLE && abort) begin
         abort_d = 1'b1;
      end

      case (state)
         IDLE: begin
            if (start) begin
               src_d      = src_start;
               dst_d      = dst_start;
               rem_d      = word_count;
               mode_d     = mode;
               fill_d     = fill_pattern;
               abort_d    = 1'b0;
               aborted_d  = 1'b0;
               checksum_d = '0;
               if (word_count == '0) begin
                  state_d = DONE;
               end else if (!mode) begin
                  state_d = RD_ISSUE;
                  addr_d  = src_start;
               end else begin
                  state_d = WR_ISSUE;
                  addr_d  = dst_start;
                  wdata_d = fill_pattern;
               end
            end
         end
         RD_ISSUE: begin
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (!mem_stall) begin
               src_d = src_inc;
               if (abort_hit) begin
                  // The read has finished; its write is dropped.
                  state_d   = DONE;
                  aborted_d = 1'b1;
               end else begin
                  state_d = WR_ISSUE;
                  addr_d  = dst_q;
                  wdata_d = mem_rdata;
               end
            end
         end
         WR_ISSUE: begin
            state_d = WR_WAIT;
         end
         WR_WAIT: begin
            if (!mem_stall) begin
               checksum_d = checksum + mem_wdata;
               dst_d      = dst_inc;
               rem_d      = rem_dec;
               if (rem_dec == '0 || abort_hit) begin
                  state_d   = DONE;
                  aborted_d = abort_hit;
               end else if (mode_q) begin
                  state_d = WR_ISSUE;
                  addr_d  = dst_inc;
                  wdata_d = fill_q;
               end else begin
                  state_d = RD_ISSUE;
                  addr_d  = src_q;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Strobes and status follow the state being entered.
      read_d  = (state_d == RD_ISSUE) || (state_d == RD_WAIT);
      write_d = (state_d == WR_ISSUE) || (state_d == WR_WAIT);
      mask_d  = (read_d || write_d) ? WORD_MASK : 4'b0000;
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
   end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-initiator block that drives the data-memory port (addr, write_data, memwrite, memread, sign_mask, read_data, clk_stall) independently of the CPU, performing word-granular block copy or pattern fill. Sits beside the processor on the data-memory interface, with an external arbiter muxing its port in while the CPU is held. Obeys the responder's clk_stall handshake: every access is held stable until the memory releases the stall. Used for boot-time memory clearing and buffer moves without CPU involvement.

## Interface
- CNT_W, 16, width of word_count and remaining-word counter
- WORD_MASK, 4'b1111, sign_mask encoding driven for full 32-bit word accesses
- clk  in  1  system clock, same domain as data memory
- rst_n  in  1  synchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- mode  in  1  0 = copy (read src, write dst), 1 = fill (write fill_pattern to dst)
- src_addr  in  32  copy source byte address; bits [1:0] ignored
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- word_count  in  CNT_W  number of 32-bit words to transfer
- fill_pattern  in  32  data written in fill mode
- abort  in  1  stop after the in-flight access completes
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse at completion or abort
- aborted  out  1  valid with done; high if terminated by abort
- checksum  out  32  modulo-2^32 sum of all data written this command
- mem_addr  out  32  data-memory address
- mem_wdata  out  32  data-memory write data
- mem_write  out  1  write request
- mem_read  out  1  read request
- mem_sign_mask  out  4  access size/sign encoding
- mem_rdata  in  32  data-memory read data
- mem_stall  in  1  responder stall (clk_stall)

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE.
- IDLE: start=1 latches all command inputs (address bits [1:0] forced 0), clears checksum and aborted; word_count=0 -> DONE, else mode=0 -> RD_ISSUE, mode=1 -> WR_ISSUE.
- RD_ISSUE: mem_read=1, mem_addr=src pointer; -> RD_WAIT unconditionally.
- RD_WAIT: mem_read, mem_addr held; while mem_stall=1 stay; mem_stall=0 -> capture mem_rdata into data register, src += 4, -> WR_ISSUE.
- WR_ISSUE: mem_write=1, mem_addr=dst pointer, mem_wdata = data register (copy) or fill_pattern (fill); -> WR_WAIT.
- WR_WAIT: outputs held; mem_stall=0 -> checksum += mem_wdata, dst += 4, remaining -= 1; remaining reaches 0 or abort latched -> DONE; else -> RD_ISSUE (copy) / WR_ISSUE (fill).
- DONE: done=1 one cycle, busy=1; -> IDLE.
- abort: sampled every busy cycle into a sticky flag; never cuts an access short; a read in progress completes and its write is skipped (-> DONE from RD_WAIT exit). aborted=1 with done.
- mem_sign_mask = WORD_MASK whenever mem_read or mem_write is high, else 0.
- Pointers wrap modulo 2^32; remaining counter never underflows.
- start during busy ignored; start and abort together in IDLE: start accepted, abort ignored.
- Overlapping src/dst regions: no special handling; ascending-address copy.

## Timing
- Reset (rst_n=0 at edge): state IDLE; busy, done, aborted, mem_read, mem_write = 0; mem_addr, mem_wdata, checksum = 0; mem_sign_mask = 0. Applies mid-access; strobes drop at that edge.
- start accepted at edge T; busy=1 and first strobe high from T+1.
- Strobes, mem_addr, mem_wdata stable from ISSUE through last WAIT cycle; never change while mem_stall=1.
- ISSUE is always exactly one cycle; completion is the first WAIT cycle with mem_stall=0.
- Zero-stall access: 2 cycles. Copy word: 4 cycles; fill word: 2 cycles; plus 1 DONE cycle.
- word_count=0: done at T+1, no memory strobes.
- checksum and aborted valid from done cycle until next accepted start.

## Test plan
- Fill, dst=0x100, count=3, pattern=0xA5A5A5A5, no stall -> writes 0x100/0x104/0x108, done at T+7, checksum=0xF0F0F0EF.
- Copy, src=0x0, dst=0x40, count=2, memory 0x11111111/0x22222222, stall high 3 cycles per access -> writes match, strobes/address constant during stall, checksum=0x33333333.
- word_count=0 -> done at T+1, no mem_read/mem_write ever high, checksum=0.
- Abort asserted during 2nd RD_WAIT of count=4 copy -> read completes, no 2nd write, done with aborted=1, checksum = first word.
- rst_n low during WR_WAIT with mem_stall=1 -> next edge all outputs 0, state IDLE; start afterwards runs normally.
- start pulsed while busy; dst_addr=0xFFFFFFFC fill count=2 -> second start ignored; addresses 0xFFFFFFFC then 0x00000000.
